apb_master_controller: RTL and testbench
========================================

// Module: apb_master_controller
// PURPOSE
//  APB-side end of the AHB2APB bridge; consumes request handshakes from the AHB slave interface.
//  Runs each request as a standard APB SETUP/ACCESS transfer on one of three APB slaves.
//  Returns a one-cycle response (read data, error) toward the AHB side.
//  Aborts stalled transfers with a wait-state timeout and keeps a saturating error count.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max ACCESS cycles with Pready low before abort; 0 = timeout disabled
//  ERRCNT_W        8   width of err_count
// PORTS
//  Hclk         in   1   clock; all state updates on rising edge
//  Hresetn      in   1   reset, asynchronous, active-low
//  req_valid    in   1   request strobe; only meaningful while bridge_ready=1
//  req_addr     in   32  request address
//  req_wdata    in   32  request write data
//  req_write    in   1   1=write, 0=read
//  req_sel      in   3   one-hot APB slave select
//  bridge_ready out  1   controller idle, can accept a request this cycle
//  Paddr        out  32  APB address
//  Pwdata       out  32  APB write data
//  Pwrite       out  1   APB direction
//  Pselx        out  3   APB slave selects (one-hot or 0)
//  Penable      out  1   APB enable
//  Pready       in   1   muxed ready from selected slave
//  Pslverr      in   1   muxed error from selected slave
//  Prdata       in   32  muxed read data from selected slave
//  rsp_valid    out  1   one-cycle response pulse
//  rsp_rdata    out  32  read data; 0 for writes and errors
//  rsp_err      out  1   slave error, timeout or bad select
//  rsp_timeout  out  1   response was a timeout abort
//  err_count    out  ERRCNT_W  saturating count of rsp_err responses
// BEHAVIOUR
//  States: IDLE, SETUP, ACCESS, RESP. All outputs are registered except bridge_ready = (state==IDLE).
//  Reset (async, any state): state=IDLE; every output 0 except bridge_ready=1; wait counter 0.
//  Reset during SETUP/ACCESS drops Pselx/Penable at once; the in-flight transfer is lost, no response.
//  IDLE: if req_valid:
//   - capture addr, wdata, write and sel; Paddr/Pwdata/Pwrite load on the same edge.
//   - req_sel one-hot -> SETUP.
//   - req_sel not one-hot (incl. 000) -> RESP with rsp_err=1; no APB activity.
//  SETUP (1 cycle): Pselx=sel, Penable=0 -> ACCESS.
//  ACCESS: Pselx=sel, Penable=1. Pready and Pslverr are sampled only in this state.
//   - Pready=1: ->RESP; rsp_err=Pslverr; rsp_rdata=Prdata if read and !Pslverr, else 0.
//   - Pready=0: wait counter +1; on the TIMEOUT_CYCLES-th such cycle -> RESP, rsp_err=1, rsp_timeout=1.
//  RESP (1 cycle): rsp_valid=1; Pselx=0, Penable=0; err_count+1 if rsp_err, holds at all-ones -> IDLE.
//  rsp_rdata/rsp_err/rsp_timeout hold until the next RESP; Paddr/Pwdata/Pwrite hold until the next capture.
//  Latency: req_valid in cycle T -> SETUP T+1, ACCESS T+2, RESP T+3+W (W = wait states), IDLE T+4+W.
//  A back-to-back request is accepted no earlier than T+4+W; minimum 4 cycles per transfer.
//  Wait counter clears on entry to ACCESS; width clog2(TIMEOUT_CYCLES+1), minimum 1.
//  Pready=1 in the same cycle the timeout would fire: completion wins, no timeout.
//  req_valid outside IDLE is ignored. Pselx is never non-zero outside SETUP/ACCESS.
// TESTING
//  Write, 0 waits: req 0x8000_0010/0xDEAD_BEEF/sel=001 at T -> Psel=001 at T+1, Penable at T+2, rsp_valid T+3 err=0.
//  Read, 2 waits, Prdata=0x1234_5678: req sel=010 -> rsp_valid at T+5, rsp_rdata=0x1234_5678, bridge_ready low T+1..T+5.
//  Pslverr=1 with Pready on read sel=100 -> rsp_err=1, rsp_rdata=0, err_count 0->1.
//  Pready stuck 0, TIMEOUT_CYCLES=16 -> Penable high exactly 16 cycles, then rsp_err=1, rsp_timeout=1.
//  req_sel=000 or 011 -> no Psel activity, rsp_valid next cycle with err=1; 300 errors -> err_count=255.
//  Hresetn low in ACCESS -> Pselx/Penable/rsp_valid 0 immediately, bridge_ready=1, next request completes.

Source files
------------

// File: rtl/apb_master_controller_if.sv
// Request/response handshake and APB bus bundle
// for the APB-side controller of the AHB2APB bridge.
interface apb_master_controller_if #(
  parameter int ERRCNT_W = 8
);
  logic                req_valid;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                req_write;
  logic [2:0]          req_sel;
  logic                bridge_ready;
  logic [31:0]         Paddr;
  logic [31:0]         Pwdata;
  logic                Pwrite;
  logic [2:0]          Pselx;
  logic                Penable;
  logic                Pready;
  logic                Pslverr;
  logic [31:0]         Prdata;
  logic                rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                rsp_timeout;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    input  req_valid, req_addr, req_wdata,
    input  req_write, req_sel,
    input  Pready, Pslverr, Prdata,
    output bridge_ready,
    output Paddr, Pwdata, Pwrite,
    output Pselx, Penable,
    output rsp_valid, rsp_rdata, rsp_err,
    output rsp_timeout, err_count
  );

  modport slave (
    output req_valid, req_addr, req_wdata,
    output req_write, req_sel,
    output Pready, Pslverr, Prdata,
    input  bridge_ready,
    input  Paddr, Pwdata, Pwrite,
    input  Pselx, Penable,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  rsp_timeout, err_count
  );
endinterface

// File: rtl/apb_master_controller.sv
// APB master: runs one SETUP/ACCESS transfer per request,
// returns a one-cycle response, times out stalled slaves.
module apb_master_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERRCNT_W       = 8
) (
  input logic Hclk,
  input logic Hresetn,
  apb_master_controller_if.master bus
);

  localparam int WCW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] LAST =
    WCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  state_t state_q, state_d;

  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic [2:0]          sel_q, sel_d;
  logic [31:0]         addr_q, wdata_q;
  logic                write_q, write_d;
  logic [2:0]          psel_q, psel_d;
  logic                pen_q, pen_d;
  logic                rv_q, rv_d;
  logic [31:0]         rd_q, rd_d;
  logic                err_q, err_d;
  logic                to_q, to_d;
  logic [ERRCNT_W-1:0] ecnt_q, ecnt_d;
  logic                cap;

  assign bus.bridge_ready = (state_q == IDLE);
  assign bus.Paddr        = addr_q;
  assign bus.Pwdata       = wdata_q;
  assign bus.Pwrite       = write_q;
  assign bus.Pselx        = psel_q;
  assign bus.Penable      = pen_q;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_rdata    = rd_q;
  assign bus.rsp_err      = err_q;
  assign bus.rsp_timeout  = to_q;
  assign bus.err_count    = ecnt_q;

  // Next state, response capture and registered-output next values
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    to_d    = to_q;
    cap     = (state_q == IDLE) && bus.req_valid;
    sel_d   = cap ? bus.req_sel : sel_q;
    write_d = cap ? bus.req_write : write_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if ($onehot(bus.req_sel)) begin
            state_d = SETUP;
          end else begin
            state_d = RESP;
            rd_d    = '0;
            err_d   = 1'b1;
            to_d    = 1'b0;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wcnt_d  = '0;
      end
      ACCESS: begin
        if (bus.Pready) begin
          state_d = RESP;
          err_d   = bus.Pslverr;
          to_d    = 1'b0;
          rd_d    = (!write_q && !bus.Pslverr)
                    ? bus.Prdata : '0;
        end else if (TIMEOUT_CYCLES != 0
                     && wcnt_q == LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          to_d    = 1'b1;
          rd_d    = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    psel_d = (state_d == SETUP || state_d == ACCESS)
             ? sel_d : 3'b000;
    pen_d  = (state_d == ACCESS);
    rv_d   = (state_d == RESP);
    ecnt_d = ecnt_q;
    if (state_d == RESP && state_q != RESP
        && err_d && !(&ecnt_q))
      ecnt_d = ecnt_q + 1'b1;
  end

  // State, captured request and registered outputs
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      psel_q  <= '0;
      pen_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      if (cap) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      psel_q  <= psel_d;
      pen_q   <= pen_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      to_q    <= to_d;
      ecnt_q  <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_controller.sv
// Randomized bench for apb_master_controller with a
// transaction-level reference model and APB slave responder.
module tb_apb_master_controller;

  localparam int TO = 16;
  localparam int EW = 8;
  localparam int EMAX = (1 << EW) - 1;

  logic Hclk;
  logic Hresetn;
  int   n_total;
  int   n_bad;
  int   ecnt;

  apb_master_controller_if #(.ERRCNT_W(EW)) bus ();

  apb_master_controller #(
    .TIMEOUT_CYCLES(TO),
    .ERRCNT_W(EW)
  ) dut (
    .Hclk(Hclk),
    .Hresetn(Hresetn),
    .bus(bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  function automatic logic [5:0] ctl();
    return {bus.bridge_ready, bus.Pselx,
            bus.Penable, bus.rsp_valid};
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_write = 1'b0;
    bus.req_sel   = '0;
    bus.Pready    = 1'b0;
    bus.Pslverr   = 1'b0;
    bus.Prdata    = '0;
  endtask

  // One complete request; w = Pready-low ACCESS cycles
  task automatic run_txn(input logic [2:0] sel,
                         input logic wr,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input int w,
                         input logic se,
                         input logic [31:0] rd);
    bit          good;
    int          e;
    int          acc;
    logic        x_err;
    logic        x_to;
    logic [31:0] x_rd;
    logic [5:0]  x_ctl;
    good = (sel == 3'b001) || (sel == 3'b010)
           || (sel == 3'b100);
    if (!good) begin
      e = 1; x_err = 1'b1; x_to = 1'b0; x_rd = '0;
    end else if (TO > 0 && w >= TO) begin
      e = 2 + TO; x_err = 1'b1; x_to = 1'b1; x_rd = '0;
    end else begin
      e = 3 + w; x_err = se; x_to = 1'b0;
      x_rd = (!wr && !se) ? rd : 32'h0;
    end
    chk("ready_before", bus.bridge_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_write = wr;
    bus.req_sel   = sel;
    acc = 0;
    for (int t = 1; t <= e; t++) begin
      tick();
      x_ctl = {1'b0,
               (good && t < e) ? sel : 3'b000,
               good && t >= 2 && t < e,
               t == e};
      chk($sformatf("ctl_t%0d", t), ctl(), x_ctl);
      if (t == 1 || t == e) begin
        chk("paddr", bus.Paddr, a);
        chk("pwdata", bus.Pwdata, wd);
        chk("pwrite", bus.Pwrite, wr);
      end
      if (t == e) begin
        chk("rsp_err", bus.rsp_err, x_err);
        chk("rsp_timeout", bus.rsp_timeout, x_to);
        chk("rsp_rdata", bus.rsp_rdata, x_rd);
      end
      if (t < e) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_write = 1'($urandom);
        bus.req_sel   = 3'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.Penable) begin
        bus.Pready  = (acc == w);
        bus.Prdata  = (acc == w) ? rd : $urandom;
        bus.Pslverr = (acc == w) ? se : 1'($urandom);
        acc++;
      end else begin
        bus.Pready  = 1'($urandom);
        bus.Pslverr = 1'($urandom);
        bus.Prdata  = $urandom;
      end
    end
    if (x_err) ecnt = (ecnt >= EMAX) ? EMAX : ecnt + 1;
    tick();
    bus.Pready = 1'b0;
    chk("ctl_after", ctl(), 6'b1_000_0_0);
    chk("err_count", bus.err_count, ecnt);
    chk("hold_rdata", bus.rsp_rdata, x_rd);
    chk("hold_err", bus.rsp_err, x_err);
    chk("hold_paddr", bus.Paddr, a);
  endtask

  initial begin
    logic [2:0]  sel_tab [4];
    logic [2:0]  s;
    int          w;
    n_total = 0;
    n_bad   = 0;
    ecnt    = 0;
    sel_tab[0] = 3'b001;
    sel_tab[1] = 3'b010;
    sel_tab[2] = 3'b100;
    sel_tab[3] = 3'b111;
    idle_inputs();
    Hresetn = 1'b0;
    #12;
    chk("rst_ctl", ctl(), 6'b1_000_0_0);
    chk("rst_paddr", bus.Paddr, 32'h0);
    chk("rst_rsp", {bus.rsp_rdata, bus.rsp_err,
                    bus.rsp_timeout}, 34'h0);
    chk("rst_ecnt", bus.err_count, 0);
    Hresetn = 1'b1;
    tick();

    run_txn(3'b001, 1'b1, 32'h8000_0010,
            32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    run_txn(3'b010, 1'b0, 32'h8000_0020,
            32'h0, 2, 1'b0, 32'h1234_5678);
    run_txn(3'b100, 1'b0, 32'h8000_0030,
            32'h0, 0, 1'b1, 32'hFFFF_0000);
    run_txn(3'b001, 1'b0, 32'h4000_0000,
            32'h0, 40, 1'b0, 32'hA5A5_A5A5);
    run_txn(3'b010, 1'b0, 32'h4000_0004,
            32'h0, TO - 1, 1'b0, 32'hCAFE_F00D);
    run_txn(3'b100, 1'b1, 32'h4000_0008,
            32'h1, TO, 1'b0, 32'h0);
    run_txn(3'b000, 1'b0, 32'h1, 32'h2, 0, 1'b0, 32'h0);
    run_txn(3'b011, 1'b1, 32'h3, 32'h4, 0, 1'b0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      s = sel_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) s = 3'($urandom);
      w = ($urandom_range(0, 7) == 0)
          ? $urandom_range(TO - 2, TO + 2)
          : $urandom_range(0, 4);
      run_txn(s, 1'($urandom), $urandom, $urandom, w,
              ($urandom_range(0, 3) == 0), $urandom);
    end

    for (int i = 0; i < 300; i++)
      run_txn(($urandom_range(0, 1) == 1) ? 3'b000 : 3'b110,
              1'($urandom), $urandom, $urandom, 0,
              1'b0, 32'h0);
    chk("ecnt_sat", bus.err_count, EMAX);

    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h9000_0000;
    bus.req_wdata = 32'h0;
    bus.req_write = 1'b0;
    bus.req_sel   = 3'b010;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("pre_rst_ctl", ctl(), 6'b0_010_1_0);
    Hresetn = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), 6'b1_000_0_0);
    chk("async_rst_ecnt", bus.err_count, 0);
    ecnt = 0;
    #2;
    Hresetn = 1'b1;
    tick();
    chk("post_rst_ctl", ctl(), 6'b1_000_0_0);
    run_txn(3'b001, 1'b0, 32'h9000_0004,
            32'h0, 1, 1'b0, 32'h0BAD_CAFE);

    $display("test done: total=%0d bad=%0d",
             n_total, n_bad);
    $finish;
  end

endmodule
